// File: rtl/led_ring_pkg.sv
// Shared sizes, default dwell and scan-state type for the LED ring scan driver.
package led_ring_pkg;

  localparam int unsigned NUM_ROWS      = 3;
  localparam int unsigned NUM_COLS      = 4;
  localparam int unsigned RING_SIZE     = 8;
  localparam int unsigned STATE_W       = $clog2(RING_SIZE);
  localparam int unsigned DWELL_DEFAULT = 4;

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2
  } scan_state_e;

  function automatic scan_state_e next_row(input scan_state_e s);
    case (s)
      ROW0:    next_row = ROW1;
      ROW1:    next_row = ROW2;
      default: next_row = ROW0;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_rom.sv
// Combinational map from (ring position, row) to the lit column set.
module led_pattern_rom
  import led_ring_pkg::*;
(
  input  logic [STATE_W-1:0]  state,
  input  logic [1:0]          row,
  output logic [NUM_COLS-1:0] col
);

  // Lower half lights column s in rows 0/1; upper half mirrors (7-s) in rows 1/2.
  always_comb begin
    col = '0;
    if (!state[2]) begin
      if (row == 2'd0 || row == 2'd1) col[state[1:0]] = 1'b1;
    end else begin
      if (row == 2'd1 || row == 2'd2) col[~state[1:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/led_scan_driver.sv
// Three-row LED scan driver with a one-entry pending register for ring-counter input.
module led_scan_driver
  import led_ring_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STATE_W-1:0]  state_i,
  input  logic                state_valid_i,
  output logic                state_ready_o,
  output logic [NUM_ROWS-1:0] row_o,
  output logic [NUM_COLS-1:0] col_o,
  output logic                frame_done_o
);

  localparam logic [7:0] DWELL_CNT = 8'(DWELL);

  scan_state_e         fsm_q, fsm_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [STATE_W-1:0]  disp_q, disp_d;
  logic [STATE_W-1:0]  pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [NUM_ROWS-1:0] row_q, row_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  logic                frame_done_q, frame_done_d;
  logic [NUM_COLS-1:0] rom_col;
  logic                accept;

  assign state_ready_o = !pend_vld_q || frame_done_q;
  assign accept        = state_valid_i && state_ready_o;

  // Pattern is looked up for the next cycle so the column drive can be registered.
  led_pattern_rom u_rom (
    .state (disp_d),
    .row   (fsm_d),
    .col   (rom_col)
  );

  always_comb begin
    if (cnt_q == DWELL_CNT) begin
      cnt_d = '0;
      fsm_d = next_row(fsm_q);
    end else begin
      cnt_d = cnt_q + 8'd1;
      fsm_d = fsm_q;
    end

    disp_d     = (frame_done_q && pend_vld_q) ? pend_q : disp_q;
    pend_d     = accept ? state_i : pend_q;
    pend_vld_d = accept ? 1'b1 : (frame_done_q ? 1'b0 : pend_vld_q);

    row_d = '0;
    col_d = '0;
    if (cnt_d != '0) begin
      row_d = {{(NUM_ROWS-1){1'b0}}, 1'b1} << fsm_d;
      col_d = rom_col;
    end
    frame_done_d = (fsm_d == ROW2) && (cnt_d == DWELL_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= ROW0;
      cnt_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_o        = row_q;
  assign col_o        = col_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with a per-cycle expected-output scoreboard.
module tb_led_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state_i = 3'd0;
  logic       valid = 1'b0;
  logic       ready, fd;
  logic [2:0] row;
  logic [3:0] col;
  logic       ready1, fd1;
  logic [2:0] row1;
  logic [3:0] col1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct packed {
    logic [2:0] row;
    logic [3:0] col;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  led_scan_driver #(.DWELL(4)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .state_i       (state_i),
    .state_valid_i (valid),
    .state_ready_o (ready),
    .row_o         (row),
    .col_o         (col),
    .frame_done_o  (fd)
  );

  led_scan_driver #(.DWELL(1)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .state_i       (3'd0),
    .state_valid_i (1'b0),
    .state_ready_o (ready1),
    .row_o         (row1),
    .col_o         (col1),
    .frame_done_o  (fd1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_col(input int unsigned s, input int unsigned r);
    int unsigned lit;
    bit          on;
    lit = (s < 4) ? s : 7 - s;
    on  = (s < 4) ? (r <= 1) : (r >= 1);
    return on ? (4'b0001 << lit) : 4'b0000;
  endfunction

  task automatic push_frame(input int unsigned s);
    exp_t e;
    for (int unsigned r = 0; r < 3; r++) begin
      e = '0;
      sb.push_back(e);
      for (int unsigned k = 1; k <= 4; k++) begin
        e.row = 3'b001 << r;
        e.col = exp_col(s, r);
        e.fd  = (r == 2) && (k == 4);
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_now();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty: observed=0 entries expected=1");
    end
    if (sb.size() != 0) begin
      checks--;
      e = sb.pop_front();
      chk("row", {5'b0, row}, {5'b0, e.row});
      chk("col", {4'b0, col}, {4'b0, e.col});
      chk("frame_done", {7'b0, fd}, {7'b0, e.fd});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic run_frame_send(input int unsigned disp, input logic [2:0] v);
    push_frame(disp);
    for (int unsigned c = 0; c < 15; c++) begin
      step();
      if (c == 1) begin valid = 1'b1; state_i = v; end
      if (c == 2) valid = 1'b0;
    end
  endtask

  initial begin
    int unsigned d;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_row", {5'b0, row}, 8'h00);
    chk("rst_col", {4'b0, col}, 8'h00);
    chk("rst_fd", {7'b0, fd}, 8'h00);
    chk("rst_ready", {7'b0, ready}, 8'h01);

    // Frame 1 after reset shows state 0; state 5 sent in cycle 3.
    rst_n = 1'b1;
    push_frame(0);
    check_now();
    chk("d1_fd_c0", {7'b0, fd1}, 8'h00);
    for (int unsigned c = 1; c < 15; c++) begin
      step();
      chk("d1_fd", {7'b0, fd1}, {7'b0, (c % 6) == 5});
      if (c == 3) begin valid = 1'b1; state_i = 3'd5; end
      if (c == 4) begin valid = 1'b0; chk("ready_c4", {7'b0, ready}, 8'h00); end
      if (c == 13) chk("ready_c13", {7'b0, ready}, 8'h00);
      if (c == 14) chk("ready_c14", {7'b0, ready}, 8'h01);
    end

    // Frame 2 shows 5; 2 then 6 sent back-to-back with valid held.
    push_frame(5);
    for (int unsigned c = 0; c < 15; c++) begin
      step();
      if (c == 0) chk("ready_f2c0", {7'b0, ready}, 8'h01);
      if (c == 1) begin valid = 1'b1; state_i = 3'd2; end
      if (c == 2) begin state_i = 3'd6; chk("ready_bp", {7'b0, ready}, 8'h00); end
      if (c == 13) chk("ready_bp13", {7'b0, ready}, 8'h00);
      if (c == 14) chk("ready_fd", {7'b0, ready}, 8'h01);
    end

    push_frame(2);
    step();
    valid = 1'b0;
    chk("ready_pend6", {7'b0, ready}, 8'h00);
    repeat (14) step();

    // Sweep 0..7 one per frame, then wrap back to 0.
    d = 6;
    for (int unsigned s = 0; s < 8; s++) begin
      run_frame_send(d, 3'(s));
      d = s;
    end
    run_frame_send(7, 3'd0);

    // Frame showing 0; pend 7, then reset in the middle of ROW1.
    push_frame(0);
    for (int unsigned c = 0; c <= 7; c++) begin
      step();
      if (c == 1) begin valid = 1'b1; state_i = 3'd7; end
      if (c == 2) valid = 1'b0;
    end
    chk("pre_rst_row", {5'b0, row}, 8'h02);
    chk("pre_rst_ready", {7'b0, ready}, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("async_row", {5'b0, row}, 8'h00);
    chk("async_col", {4'b0, col}, 8'h00);
    chk("async_fd", {7'b0, fd}, 8'h00);
    chk("async_ready", {7'b0, ready}, 8'h01);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    push_frame(0);
    push_frame(0);
    check_now();
    chk("d1_fd_r0", {7'b0, fd1}, 8'h00);
    for (int unsigned c = 1; c < 30; c++) begin
      step();
      chk("d1_fd_r", {7'b0, fd1}, {7'b0, (c % 6) == 5});
      if (c == 1) chk("ready_after_rst", {7'b0, ready}, 8'h01);
    end
    chk("sb_drained", 8'(sb.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
